vga_scan_counter: RTL

Raster scan generator for the 640x480@60 VGA path. It divides the system clock into a pixel-rate tick and drives the 10-bit horizontal and vertical position counters consumed by the sync/decode stage. The decode stage turns these counts into `h_sync`, `v_sync`, `video_enable` and pixel coordinates. This block also supplies line-end and frame-end strobes for game logic that must update only between frames.

---
 rtl/vga_scan_counter.sv | 69 ++++++
 1 files changed

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: pixel-rate divider and raster position counters with line/frame strobes; frame counter under VGA_FRAME_COUNT_EN
module vga_scan_counter #(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    output logic       pix_tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       line_end,
    output logic       frame_end
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 16 || H_TOTAL < 2 || H_TOTAL > 1024 || V_TOTAL < 2 || V_TOTAL > 1024) begin : g_bad_param
            $error("vga_scan_counter: parameter out of range");
        end
    endgenerate

    logic [DW-1:0] div_cnt;

    // strobes decode registered state, gated by run control so a frozen or clearing cycle emits nothing
    always_comb begin
        pix_tick  = enable & ~clear & (div_cnt == DIV_LAST);
        line_end  = pix_tick & (h_count == H_LAST);
        frame_end = line_end & (v_count == V_LAST);
    end

    // clock divider: free-runs while enabled, holds its phase while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else if (clear) div_cnt <= '0;
        else if (enable) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end

    // raster position: advances one pixel per tick, line wrap carries into the line counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (clear) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_tick) begin
            h_count <= line_end ? '0 : h_count + 10'd1;
            if (line_end) v_count <= frame_end ? '0 : v_count + 10'd1;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // completed-frame counter; survives clear, only reset zeroes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_count <= '0;
        else if (frame_end) frame_count <= frame_count + 8'd1;
    end
`endif
endmodule
